// File: rtl/coeff_bank_dbuf.sv
// -----------------------------------------------------------------------------
// coeff_bank_dbuf
//
// Purpose:
//   Runtime-reloadable, double-buffered coefficient store for a symmetric
//   (odd-length, linear-phase) FIR. Only the unique half of the taps is
//   stored. New coefficients are streamed into a shadow bank while the FIR
//   keeps reading the active bank. The banks swap in a single cycle, and
//   only on a frame boundary, so a frame never sees a mix of old and new
//   taps. The read port mirrors tap addresses, so the FIR can address all
//   NTAPS taps directly.
//
// Parameters:
//   COEFF_W        coefficient width (two's complement, Q2.(COEFF_W-3))
//   NTAPS          total tap count; must be odd and >= 3
//   DEFAULT_COEFFS HALF*COEFF_W packed reset contents of both banks.
//                  Element i sits at [i*COEFF_W +: COEFF_W]. The default is
//                  a passthrough: only the centre tap (HALF-1) is 1.0.
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_ld_valid     load word valid
//   o_ld_ready     block accepts a load word (low only while a complete
//                  shadow bank waits for its swap)
//   i_ld_data      coefficient; the k-th word of a load targets unique index k
//   i_ld_last      marks the final word of a load
//   i_frame_sync   one-cycle pulse at the FIR frame boundary (swap point)
//   i_rd_en        read request
//   i_rd_addr      tap index 0..NTAPS-1 (out-of-range addresses read as 0)
//   o_rd_data      registered coefficient, one cycle after i_rd_en
//   o_rd_valid     o_rd_data is valid
//   o_swap_done    one-cycle pulse after the active bank has been updated
//   o_load_err     one-cycle pulse after a malformed load is dropped
//   o_pending      shadow bank is complete and waiting for i_frame_sync
//   o_coef_ver     count of completed swaps, wraps 255 -> 0
//   o_fsm_state    debug view of the load FSM
//                  (0 = IDLE, 1 = LOADING, 2 = PENDING)
// -----------------------------------------------------------------------------
module coeff_bank_dbuf #(
    parameter int COEFF_W = 16,
    parameter int NTAPS   = 31,
    parameter logic [((NTAPS+1)/2)*COEFF_W-1:0] DEFAULT_COEFFS =
        {COEFF_W'(16'h2000), {(((NTAPS+1)/2-1)*COEFF_W){1'b0}}}
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ld_valid,
    output logic                       o_ld_ready,
    input  logic [COEFF_W-1:0]         i_ld_data,
    input  logic                       i_ld_last,
    input  logic                       i_frame_sync,
    input  logic                       i_rd_en,
    input  logic [$clog2(NTAPS)-1:0]   i_rd_addr,
    output logic [COEFF_W-1:0]         o_rd_data,
    output logic                       o_rd_valid,
    output logic                       o_swap_done,
    output logic                       o_load_err,
    output logic                       o_pending,
    output logic [7:0]                 o_coef_ver,
    output logic [1:0]                 o_fsm_state
);

    localparam int HALF = (NTAPS + 1) / 2;
    localparam int AW   = $clog2(NTAPS);
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOADING = 2'd1,
        ST_PENDING = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [IW-1:0]        r_idx;
    logic [IW-1:0]        w_idx_next;

    logic [COEFF_W-1:0]   r_active [HALF];
    logic [COEFF_W-1:0]   r_shadow [HALF];

    logic                 w_ld_ready;
    logic                 w_accept;
    logic                 w_swap;
    logic                 w_err;

    logic                 r_swap_done;
    logic                 r_load_err;
    logic [7:0]           r_coef_ver;
    logic [COEFF_W-1:0]   r_rd_data;
    logic                 r_rd_valid;

    logic                 w_in_range;
    logic [AW-1:0]        w_mirror;
    logic [IW-1:0]        w_u;

    // Load handshake: a word transfers on every rising clock edge where
    // i_ld_valid and o_ld_ready are both high. o_ld_ready depends only on the
    // FSM state (never on i_ld_valid), so the sender may hold i_ld_valid and
    // its data stable until ready returns; nothing is consumed while ready is
    // low.
    assign w_ld_ready = (r_state != ST_PENDING);
    assign w_accept   = i_ld_valid && w_ld_ready;

    // -------------------------------------------------------------------------
    // Load FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err        = 1'b0;
        w_swap       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // NTAPS >= 3 means HALF >= 2, so a one-word load is
                    // always too short.
                    if (i_ld_last) begin
                        w_err      = 1'b1;
                        w_idx_next = '0;
                    end else begin
                        w_state_next = ST_LOADING;
                        w_idx_next   = IW'(1);
                    end
                end
            end

            ST_LOADING: begin
                if (w_accept) begin
                    if (r_idx == IW'(HALF - 1)) begin
                        // Final slot: it must carry ld_last, otherwise the
                        // sender's framing is wrong and the load is dropped.
                        w_idx_next = '0;
                        if (i_ld_last) begin
                            w_state_next = ST_PENDING;
                        end else begin
                            w_state_next = ST_IDLE;
                            w_err        = 1'b1;
                        end
                    end else if (i_ld_last) begin
                        w_state_next = ST_IDLE;
                        w_idx_next   = '0;
                        w_err        = 1'b1;
                    end else begin
                        w_idx_next = r_idx + IW'(1);
                    end
                end
            end

            ST_PENDING: begin
                // Only a sync seen while already PENDING swaps; a sync that
                // coincides with the final load word is seen in LOADING and
                // is ignored.
                if (i_frame_sync) begin
                    w_swap       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Load FSM: state register, status pulses and swap counter
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_swap_done <= 1'b0;
            r_load_err  <= 1'b0;
            r_coef_ver  <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_idx       <= w_idx_next;
            r_swap_done <= w_swap;
            r_load_err  <= w_err;
            if (w_swap) begin
                r_coef_ver <= r_coef_ver + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Coefficient banks
    // -------------------------------------------------------------------------
    // The shadow is written on every accepted word, including words of a load
    // that later turns out malformed. That is harmless: a partial shadow can
    // never reach PENDING, and the next good load rewrites every slot before
    // it can be swapped in. r_idx is 0 in IDLE, so the first word lands in
    // slot 0.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < HALF; i++) begin
                r_active[i] <= DEFAULT_COEFFS[i*COEFF_W +: COEFF_W];
                r_shadow[i] <= DEFAULT_COEFFS[i*COEFF_W +: COEFF_W];
            end
        end else begin
            if (w_accept) begin
                r_shadow[r_idx] <= i_ld_data;
            end
            if (w_swap) begin
                for (int i = 0; i < HALF; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read path: fold the tap address onto the stored half
    // -------------------------------------------------------------------------
    // Tap t and tap NTAPS-1-t share one stored coefficient. The mirrored
    // value is only meaningful when the address is in range; out-of-range
    // addresses are forced to zero below, so the wrapped w_mirror for those
    // addresses is never used.
    assign w_in_range = (i_rd_addr < AW'(NTAPS));
    assign w_mirror   = AW'(NTAPS - 1) - i_rd_addr;
    assign w_u        = (i_rd_addr < AW'(HALF)) ? IW'(i_rd_addr) : IW'(w_mirror);

    // Reads sample r_active before any swap on the same edge takes effect,
    // so a read issued in the swap cycle returns the old coefficient.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_in_range ? r_active[w_u] : '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_ld_ready  = w_ld_ready;
    assign o_pending   = (r_state == ST_PENDING);
    assign o_rd_data   = r_rd_data;
    assign o_rd_valid  = r_rd_valid;
    assign o_swap_done = r_swap_done;
    assign o_load_err  = r_load_err;
    assign o_coef_ver  = r_coef_ver;
    assign o_fsm_state = r_state;

endmodule

// File: tb/tb_coeff_bank_dbuf.sv
// -----------------------------------------------------------------------------
// tb_coeff_bank_dbuf
//
// Purpose:
//   Self-checking bench for coeff_bank_dbuf. A driver applies one cycle of
//   stimulus at a time and updates a tap-level reference model: the full
//   NTAPS tap array, the list of words in the current load, a pending flag
//   and the swap count. Read results and swap/error events expected from
//   each cycle are queued. A negedge monitor pops these queues whenever the
//   DUT presents rd_valid, swap_done or load_err.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_coeff_bank_dbuf;

    localparam int COEFF_W = 16;
    localparam int NTAPS   = 31;
    localparam int HALF    = (NTAPS + 1) / 2;
    localparam int AW      = $clog2(NTAPS);

    // Debug encoding exposed on o_fsm_state
    localparam logic [1:0] FSM_IDLE    = 2'd0;
    localparam logic [1:0] FSM_LOADING = 2'd1;
    localparam logic [1:0] FSM_PENDING = 2'd2;

    localparam logic [1:0] EVT_SWAP = 2'd1;
    localparam logic [1:0] EVT_ERR  = 2'd2;

    // ---------------------------------------------------------------- clock/reset
    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ld_valid = 1'b0;
    logic               ld_ready;
    logic [COEFF_W-1:0] ld_data = '0;
    logic               ld_last = 1'b0;
    logic               frame_sync = 1'b0;
    logic               rd_en = 1'b0;
    logic [AW-1:0]      rd_addr = '0;
    logic [COEFF_W-1:0] rd_data;
    logic               rd_valid;
    logic               swap_done;
    logic               load_err;
    logic               pending;
    logic [7:0]         coef_ver;
    logic [1:0]         fsm_state;

    always #5 clk = ~clk;

    coeff_bank_dbuf dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_ld_valid   (ld_valid),
        .o_ld_ready   (ld_ready),
        .i_ld_data    (ld_data),
        .i_ld_last    (ld_last),
        .i_frame_sync (frame_sync),
        .i_rd_en      (rd_en),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .o_rd_valid   (rd_valid),
        .o_swap_done  (swap_done),
        .o_load_err   (load_err),
        .o_pending    (pending),
        .o_coef_ver   (coef_ver),
        .o_fsm_state  (fsm_state)
    );

    // ---------------------------------------------------------------- scoreboard
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [COEFF_W-1:0] exp_q[$];
    logic [9:0]         exp_evt_q[$];

    // ---------------------------------------------------------------- reference model
    logic [COEFF_W-1:0] m_taps   [NTAPS];
    logic [COEFF_W-1:0] m_shadow [HALF];
    logic [COEFF_W-1:0] m_load[$];
    logic               m_pending;
    int                 m_ver;
    logic [COEFF_W-1:0] m_rd_hold;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NTAPS; t++) m_taps[t] = '0;
        m_taps[HALF-1] = 16'h2000;      // 1.0 on the centre tap
        m_load.delete();
        m_pending = 1'b0;
        m_ver     = 0;
        m_rd_hold = '0;
    endtask

    // ---------------------------------------------------------------- monitor
    logic [COEFF_W-1:0] mon_exp;
    logic [9:0]         mon_evt;
    logic [1:0]         mon_kind;

    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rd_unexpected: rd_valid with data %h, expected no read", rd_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("rd_data", {16'h0, rd_data}, {16'h0, mon_exp});
            end
        end else if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rd_missing: rd_valid %b, expected data %h", rd_valid, mon_exp);
        end

        if (swap_done === 1'b1 || load_err === 1'b1) begin
            mon_kind = (swap_done === 1'b1) ? EVT_SWAP : EVT_ERR;
            if (exp_evt_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL evt_unexpected: swap_done %b load_err %b, expected none",
                         swap_done, load_err);
            end else begin
                mon_evt = exp_evt_q.pop_front();
                check("event_kind_ver", {22'h0, mon_kind, coef_ver}, {22'h0, mon_evt});
            end
        end else if (exp_evt_q.size() != 0) begin
            mon_evt = exp_evt_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL evt_missing: no swap_done/load_err, expected kind %0d ver %0d",
                     mon_evt[9:8], mon_evt[7:0]);
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // One clock cycle of stimulus. Inputs are applied at posedge+1 and the
    // model is advanced by what should happen at the following posedge.
    task automatic drive(input logic v, input logic [COEFF_W-1:0] d, input logic l,
                         input logic s, input logic re, input logic [AW-1:0] a);
        logic               acc;
        logic               swp;
        logic [COEFF_W-1:0] rexp;
        logic [1:0]         exp_state;
        ld_valid   = v;
        ld_data    = d;
        ld_last    = l;
        frame_sync = s;
        rd_en      = re;
        rd_addr    = a;
        rexp = '0;
        if (int'(a) < NTAPS) rexp = m_taps[a];
        swp = s && m_pending;
        acc = v && !m_pending;
        @(posedge clk);
        if (re) exp_q.push_back(rexp);
        if (swp) begin
            for (int k = 0; k < HALF; k++) begin
                m_taps[k]           = m_shadow[k];
                m_taps[NTAPS-1-k]   = m_shadow[k];
            end
            m_ver     = (m_ver + 1) % 256;
            m_pending = 1'b0;
            exp_evt_q.push_back({EVT_SWAP, 8'(m_ver)});
        end
        if (acc) begin
            m_load.push_back(d);
            if (l || m_load.size() == HALF) begin
                if (l && m_load.size() == HALF) begin
                    for (int k = 0; k < HALF; k++) m_shadow[k] = m_load[k];
                    m_pending = 1'b1;
                end else begin
                    exp_evt_q.push_back({EVT_ERR, 8'(m_ver)});
                end
                m_load.delete();
            end
        end
        #1;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        frame_sync = 1'b0;
        rd_en      = 1'b0;
        exp_state = m_pending ? FSM_PENDING : ((m_load.size() > 0) ? FSM_LOADING : FSM_IDLE);
        check("ld_ready", {31'h0, ld_ready}, {31'h0, !m_pending});
        check("pending", {31'h0, pending}, {31'h0, m_pending});
        check("fsm_state", {30'h0, fsm_state}, {30'h0, exp_state});
        if (!re) check("rd_hold", {16'h0, rd_data}, {16'h0, m_rd_hold});
        else     m_rd_hold = rexp;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic rd(input int a);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, AW'(a));
    endtask

    task automatic sync();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    endtask

    // Sends n words base+k; ld_last on word last_at (-1 = never); optional
    // frame_sync on the final word.
    task automatic load_words(input logic [COEFF_W-1:0] base, input int n,
                              input int last_at, input logic sync_on_final);
        for (int k = 0; k < n; k++)
            drive(1'b1, base + COEFF_W'(k), (k == last_at), sync_on_final && (k == n-1),
                  1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst        = 1'b1;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        frame_sync = 1'b0;
        rd_en      = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_rd_data", {16'h0, rd_data}, 32'h0);
        check("rst_rd_valid", {31'h0, rd_valid}, 32'h0);
        check("rst_swap_done", {31'h0, swap_done}, 32'h0);
        check("rst_load_err", {31'h0, load_err}, 32'h0);
        check("rst_pending", {31'h0, pending}, 32'h0);
        check("rst_coef_ver", {24'h0, coef_ver}, 32'h0);
        check("rst_ld_ready", {31'h0, ld_ready}, 32'h1);
        check("rst_fsm_state", {30'h0, fsm_state}, {30'h0, FSM_IDLE});
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------------------------------------------------------- watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- test sequence
    initial begin
        logic               v;
        logic               l;
        logic               s;
        logic               re;
        model_reset();
        do_reset();

        // Reset contents: passthrough set
        rd(15); rd(0); rd(30); rd(31);
        idle(1);

        // Full load then swap; pending holds until sync
        load_words(16'h0100, HALF, HALF-1, 1'b0);
        idle(3);
        sync();
        idle(1);
        check("coef_ver_first_swap", {24'h0, coef_ver}, 32'(m_ver));
        rd(3); rd(27); rd(15);

        // frame_sync coincident with final word must not swap
        load_words(16'h0200, HALF, HALF-1, 1'b1);
        idle(1);
        rd(15);
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, AW'(15));   // read in swap cycle: old value
        rd(15); rd(16); rd(0);

        // Malformed: early last, then missing last; active bank unchanged
        load_words(16'h0700, 6, 5, 1'b0);
        idle(1);
        rd(15);
        load_words(16'h0800, HALF, -1, 1'b0);
        idle(1);
        rd(15); rd(2);
        sync();                                        // no swap outside PENDING
        rd(29);

        // Backpressure while PENDING
        load_words(16'h0300, HALF, HALF-1, 1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, '0);
        sync();
        for (int a = 0; a <= NTAPS; a++) rd(a);

        // Reset mid-load, then a full load still works
        load_words(16'h0400, 8, -1, 1'b0);
        do_reset();
        rd(15);
        load_words(16'h0500, HALF, HALF-1, 1'b0);
        sync();
        rd(0); rd(30); rd(15);

        // 256 load/swap cycles from reset wrap coef_ver back to 0
        do_reset();
        for (int n = 0; n < 256; n++) begin
            load_words(16'($urandom), HALF, HALF-1, 1'b0);
            sync();
        end
        idle(1);
        check("coef_ver_wrap", {24'h0, coef_ver}, 32'(m_ver));
        rd(7); rd(23);

        // Randomised traffic: loads with gaps, occasional bad framing,
        // random syncs and reads
        for (int c = 0; c < 3000; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            if (m_load.size() == HALF - 1) l = ($urandom_range(0, 9) != 0);
            else                           l = ($urandom_range(0, 59) == 0);
            s  = ($urandom_range(0, 5) == 0);
            re = ($urandom_range(0, 1) == 1);
            drive(v, 16'($urandom), l, s, re, AW'($urandom_range(0, NTAPS)));
        end

        idle(3);
        check("rd_queue_drained", 32'(exp_q.size()), 32'h0);
        check("evt_queue_drained", 32'(exp_evt_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
